// File: rtl/bin2bcd_display.sv
// Iterative shift-add-3 binary-to-BCD converter feeding the seven-segment Display data input.
// Optional macro BIN2BCD_OVF_SAT_EN: saturate bcd to all nines when the value overflows DIGITS digits.
module bin2bcd_display #(
  parameter int unsigned BIN_WIDTH = 32,
  parameter int unsigned DIGITS    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BIN_WIDTH-1:0]   bin,
  output logic                   ready,
  output logic                   valid,
  output logic [4*DIGITS-1:0]    bcd,
  output logic                   overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]     scr_q, scr_d;
  logic                 ovf_scr_q, ovf_scr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic [BCD_W-1:0]     corr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scr_q     <= '0;
      ovf_scr_q <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scr_q     <= scr_d;
      ovf_scr_q <= ovf_scr_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  // Per-nibble add-3 correction; no carry crosses a nibble boundary.
  always_comb begin
    corr = scr_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        corr[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scr_d     = scr_q;
    ovf_scr_d = ovf_scr_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d   = bin;
          scr_d     = '0;
          ovf_scr_d = 1'b0;
          cnt_d     = CNT_W'(BIN_WIDTH);
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scr_d, shift_d} = {corr, shift_q} << 1;
        ovf_scr_d        = ovf_scr_q | corr[BCD_W-1];
        cnt_d            = cnt_q - 1'b1;
        // Last shift: publish the just-computed scratch so the output only ever holds final values.
        if (cnt_q == CNT_W'(1)) begin
          ovf_d   = ovf_scr_d;
`ifdef BIN2BCD_OVF_SAT_EN
          bcd_d   = ovf_scr_d ? {DIGITS{4'h9}} : scr_d;
`else
          bcd_d   = scr_d;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready    = (state_q == S_IDLE);
  assign valid    = (state_q == S_DONE);
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule
